// File: rtl/memory_io_responder.sv
// ---------------------------------------------------------------------------
// memory_io_responder
//
// Purpose:
//   Responder end of the CPU datapath memory interface. Accepts MAR/MDR
//   requests (MIO_EN, R_W), runs an async SRAM cycle with WAIT_CYCLES wait
//   states, or services the memory-mapped console registers at xFE00-xFE06.
//   Every completed access returns a one-cycle ready pulse R; reads also
//   update Data_Out, which holds until the next read completes.
//
// Ports:
//   Clk, Reset          system clock (rising edge), async active-high reset
//   MIO_EN, R_W         request strobe (held until R) and direction (1=write)
//   Address, Data_In    access address (MAR) and write data (MDR)
//   Data_Out, R         read data and one-cycle completion pulse
//   SRAM_ADDR           SRAM address, captured at request accept
//   SRAM_DQ_OUT/_IN/_OE SRAM write data, read data, bus drive enable
//   SRAM_CE_N/OE_N/WE_N SRAM control strobes, active-low
//   KB_Data, KB_Valid   keyboard character and its one-cycle strobe
//   DSP_Ready           display sink can accept a character
//   DSP_Data, DSP_Valid display character and its one-cycle strobe
//
// Register map (device space is xFE00-xFFFF):
//   xFE00 KBSR (R)  {kb_ready, 15'b0}
//   xFE02 KBDR (R)  {8'b0, kb_data}; reading clears kb_ready
//   xFE04 DSR  (R)  {DSP_Ready, 15'b0}
//   xFE06 DDR  (W)  DSP_Data <= Data_In[7:0], DSP_Valid pulses
//   Any other device address reads 0 and ignores writes.
// ---------------------------------------------------------------------------
module memory_io_responder #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,

    input  logic        MIO_EN,
    input  logic        R_W,
    input  logic [15:0] Address,
    input  logic [15:0] Data_In,
    output logic [15:0] Data_Out,
    output logic        R,

    output logic [15:0] SRAM_ADDR,
    output logic [15:0] SRAM_DQ_OUT,
    input  logic [15:0] SRAM_DQ_IN,
    output logic        SRAM_DQ_OE,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_WE_N,

    input  logic [7:0]  KB_Data,
    input  logic        KB_Valid,
    input  logic        DSP_Ready,
    output logic [7:0]  DSP_Data,
    output logic        DSP_Valid
);

    // Counter must hold WAIT_CYCLES; keep at least one bit.
    localparam int unsigned CNT_W =
        (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);

    localparam logic [15:0] ADDR_KBSR = 16'hFE00;
    localparam logic [15:0] ADDR_KBDR = 16'hFE02;
    localparam logic [15:0] ADDR_DSR  = 16'hFE04;
    localparam logic [15:0] ADDR_DDR  = 16'hFE06;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SRAM_RD = 2'd1,
        SRAM_WR = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t           state_q,       state_d;
    logic [CNT_W-1:0] cnt_q,         cnt_d;
    logic [15:0]      data_out_q,    data_out_d;
    logic [15:0]      sram_addr_q,   sram_addr_d;
    logic [15:0]      sram_dq_out_q, sram_dq_out_d;
    logic             kb_ready_q,    kb_ready_d;
    logic [7:0]       kb_data_q,     kb_data_d;
    logic [7:0]       dsp_data_q,    dsp_data_d;
    logic             dsp_valid_q,   dsp_valid_d;

    logic             is_dev;
    logic [15:0]      dev_rdata;

    // -----------------------------------------------------------------------
    // Address decode and device read mux
    // -----------------------------------------------------------------------
    always_comb begin
        is_dev    = &Address[15:9];
        dev_rdata = '0;
        case (Address)
            ADDR_KBSR: dev_rdata = {kb_ready_q, 15'b0};
            ADDR_KBDR: dev_rdata = {8'b0, kb_data_q};
            ADDR_DSR:  dev_rdata = {DSP_Ready, 15'b0};
            default:   dev_rdata = '0;
        endcase
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            data_out_q    <= '0;
            sram_addr_q   <= '0;
            sram_dq_out_q <= '0;
            kb_ready_q    <= 1'b0;
            kb_data_q     <= '0;
            dsp_data_q    <= '0;
            dsp_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            data_out_q    <= data_out_d;
            sram_addr_q   <= sram_addr_d;
            sram_dq_out_q <= sram_dq_out_d;
            kb_ready_q    <= kb_ready_d;
            kb_data_q     <= kb_data_d;
            dsp_data_q    <= dsp_data_d;
            dsp_valid_q   <= dsp_valid_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        data_out_d    = data_out_q;
        sram_addr_d   = sram_addr_q;
        sram_dq_out_d = sram_dq_out_q;
        kb_ready_d    = kb_ready_q;
        kb_data_d     = kb_data_q;
        dsp_data_d    = dsp_data_q;
        dsp_valid_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (MIO_EN) begin
                    if (is_dev) begin
                        // Device registers complete in a single cycle; the
                        // side effects are applied at the accept edge.
                        state_d = DONE;
                        if (!R_W) begin
                            data_out_d = dev_rdata;
                            if (Address == ADDR_KBDR) begin
                                kb_ready_d = 1'b0;
                            end
                        end else if (Address == ADDR_DDR) begin
                            dsp_data_d  = Data_In[7:0];
                            dsp_valid_d = 1'b1;
                        end
                    end else begin
                        sram_addr_d = Address;
                        cnt_d       = CNT_LOAD;
                        if (R_W) begin
                            state_d       = SRAM_WR;
                            sram_dq_out_d = Data_In;
                        end else begin
                            state_d = SRAM_RD;
                        end
                    end
                end
            end

            SRAM_RD: begin
                if (cnt_q == '0) begin
                    data_out_d = SRAM_DQ_IN;
                    state_d    = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            SRAM_WR: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // A new keystroke wins over a same-edge KBDR read clearing the flag;
        // the read itself still returns the previous character.
        if (KB_Valid) begin
            kb_data_d  = KB_Data;
            kb_ready_d = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs: SRAM strobes decode from the state register so that reset
    // deasserts them without waiting for a clock edge.
    // -----------------------------------------------------------------------
    always_comb begin
        R           = (state_q == DONE);
        SRAM_CE_N   = !((state_q == SRAM_RD) || (state_q == SRAM_WR));
        SRAM_OE_N   = !(state_q == SRAM_RD);
        // Final write cycle (counter at zero) is a hold cycle with WE_N high.
        SRAM_WE_N   = !((state_q == SRAM_WR) && (cnt_q != '0));
        SRAM_DQ_OE  = (state_q == SRAM_WR);
        SRAM_ADDR   = sram_addr_q;
        SRAM_DQ_OUT = sram_dq_out_q;
        Data_Out    = data_out_q;
        DSP_Data    = dsp_data_q;
        DSP_Valid   = dsp_valid_q;
    end

endmodule

// File: tb/tb_memory_io_responder.sv
// Directed bench for memory_io_responder with WAIT_CYCLES = 2 and a simple
// async SRAM model (reads while CE_N/OE_N low, writes on WE_N rising edge).
module tb_memory_io_responder;

    logic        Clk;
    logic        Reset;
    logic        MIO_EN;
    logic        R_W;
    logic [15:0] Address;
    logic [15:0] Data_In;
    logic [15:0] Data_Out;
    logic        R;
    logic [15:0] SRAM_ADDR;
    logic [15:0] SRAM_DQ_OUT;
    logic [15:0] SRAM_DQ_IN;
    logic        SRAM_DQ_OE;
    logic        SRAM_CE_N;
    logic        SRAM_OE_N;
    logic        SRAM_WE_N;
    logic [7:0]  KB_Data;
    logic        KB_Valid;
    logic        DSP_Ready;
    logic [7:0]  DSP_Data;
    logic        DSP_Valid;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] mem [0:65535];

    memory_io_responder #(.WAIT_CYCLES(2)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .MIO_EN      (MIO_EN),
        .R_W         (R_W),
        .Address     (Address),
        .Data_In     (Data_In),
        .Data_Out    (Data_Out),
        .R           (R),
        .SRAM_ADDR   (SRAM_ADDR),
        .SRAM_DQ_OUT (SRAM_DQ_OUT),
        .SRAM_DQ_IN  (SRAM_DQ_IN),
        .SRAM_DQ_OE  (SRAM_DQ_OE),
        .SRAM_CE_N   (SRAM_CE_N),
        .SRAM_OE_N   (SRAM_OE_N),
        .SRAM_WE_N   (SRAM_WE_N),
        .KB_Data     (KB_Data),
        .KB_Valid    (KB_Valid),
        .DSP_Ready   (DSP_Ready),
        .DSP_Data    (DSP_Data),
        .DSP_Valid   (DSP_Valid)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    assign SRAM_DQ_IN = (SRAM_CE_N === 1'b0 && SRAM_OE_N === 1'b0) ? mem[SRAM_ADDR] : 16'hDEAD;

    always @(posedge SRAM_WE_N) begin
        if (SRAM_CE_N === 1'b0 && SRAM_DQ_OE === 1'b1) mem[SRAM_ADDR] = SRAM_DQ_OUT;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Drives one access and waits (bounded) for R; returns in an idle cycle.
    task automatic do_access(input logic rw, input logic [15:0] addr, input logic [15:0] wdata,
                             output logic [15:0] rdata, output int lat);
        MIO_EN = 1'b1; R_W = rw; Address = addr; Data_In = wdata;
        lat = -1; rdata = 16'h0000;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (R === 1'b1) begin
                lat = c;
                rdata = Data_Out;
                break;
            end
        end
        MIO_EN = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        Reset = 1'b1; MIO_EN = 1'b0; R_W = 1'b0; Address = '0; Data_In = '0;
        KB_Data = '0; KB_Valid = 1'b0; DSP_Ready = 1'b0;
        tick(); tick();
        n_checks++; if (R !== 1'b0) begin n_fail++; $display("FAIL reset_R: got %b want 0", R); end
        n_checks++; if (Data_Out !== 16'h0000) begin n_fail++; $display("FAIL reset_DataOut: got %h want 0000", Data_Out); end
        n_checks++; if ({SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_DQ_OE} !== 4'b1110) begin
            n_fail++; $display("FAIL reset_strobes: got %b want 1110", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_DQ_OE}); end
        n_checks++; if (SRAM_ADDR !== 16'h0000 || SRAM_DQ_OUT !== 16'h0000) begin
            n_fail++; $display("FAIL reset_sram_regs: got %h/%h want 0000/0000", SRAM_ADDR, SRAM_DQ_OUT); end
        n_checks++; if (DSP_Data !== 8'h00 || DSP_Valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_dsp: got %h/%b want 00/0", DSP_Data, DSP_Valid); end
        Reset = 1'b0;
        tick();
    endtask

    task automatic test_sram_read();
        logic exp_low;
        MIO_EN = 1'b1; R_W = 1'b0; Address = 16'h3000;
        n_checks++; if (SRAM_CE_N !== 1'b1 || R !== 1'b0) begin
            n_fail++; $display("FAIL rd_c0: got CE_N=%b R=%b want 1/0", SRAM_CE_N, R); end
        for (int c = 1; c <= 5; c++) begin
            tick();
            exp_low = (c <= 3);
            n_checks++; if (SRAM_CE_N !== !exp_low || SRAM_OE_N !== !exp_low || SRAM_WE_N !== 1'b1) begin
                n_fail++; $display("FAIL rd_strobes c%0d: got CE_N=%b OE_N=%b WE_N=%b want %b/%b/1",
                                   c, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, !exp_low, !exp_low); end
            n_checks++; if (R !== (c == 4)) begin
                n_fail++; $display("FAIL rd_R c%0d: got %b want %b", c, R, (c == 4)); end
            if (c == 1) begin
                n_checks++; if (SRAM_ADDR !== 16'h3000) begin
                    n_fail++; $display("FAIL rd_addr: got %h want 3000", SRAM_ADDR); end
            end
            if (c == 4) begin
                n_checks++; if (Data_Out !== 16'hBEEF) begin
                    n_fail++; $display("FAIL rd_data: got %h want beef", Data_Out); end
                MIO_EN = 1'b0;
            end
        end
    endtask

    task automatic test_sram_write();
        logic [15:0] rd;
        int lat;
        MIO_EN = 1'b1; R_W = 1'b1; Address = 16'h4000; Data_In = 16'h1234;
        for (int c = 1; c <= 4; c++) begin
            tick();
            n_checks++; if (SRAM_WE_N !== !(c <= 2) || SRAM_CE_N !== !(c <= 3) ||
                            SRAM_DQ_OE !== (c <= 3) || SRAM_OE_N !== 1'b1) begin
                n_fail++; $display("FAIL wr_strobes c%0d: got WE_N=%b CE_N=%b DQ_OE=%b OE_N=%b want %b/%b/%b/1",
                                   c, SRAM_WE_N, SRAM_CE_N, SRAM_DQ_OE, SRAM_OE_N, !(c <= 2), !(c <= 3), (c <= 3)); end
            n_checks++; if (R !== (c == 4)) begin
                n_fail++; $display("FAIL wr_R c%0d: got %b want %b", c, R, (c == 4)); end
            if (c == 1) begin
                n_checks++; if (SRAM_DQ_OUT !== 16'h1234 || SRAM_ADDR !== 16'h4000) begin
                    n_fail++; $display("FAIL wr_bus: got %h@%h want 1234@4000", SRAM_DQ_OUT, SRAM_ADDR); end
            end
            if (c == 4) begin
                n_checks++; if (Data_Out !== 16'hBEEF) begin
                    n_fail++; $display("FAIL wr_dataout_held: got %h want beef", Data_Out); end
            end
        end
        MIO_EN = 1'b0;
        tick();
        do_access(1'b0, 16'h4000, 16'h0000, rd, lat);
        n_checks++; if (rd !== 16'h1234) begin n_fail++; $display("FAIL wr_readback: got %h want 1234", rd); end
        n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL rd_latency: got %0d want 4", lat); end
    endtask

    task automatic test_keyboard();
        logic [15:0] rd;
        int lat;
        KB_Data = 8'h41; KB_Valid = 1'b1; tick(); KB_Valid = 1'b0;
        do_access(1'b0, 16'hFE00, 16'h0000, rd, lat);
        n_checks++; if (rd !== 16'h8000) begin n_fail++; $display("FAIL kbsr_ready: got %h want 8000", rd); end
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL kbsr_latency: got %0d want 1", lat); end
        do_access(1'b0, 16'hFE02, 16'h0000, rd, lat);
        n_checks++; if (rd !== 16'h0041 || lat !== 1) begin
            n_fail++; $display("FAIL kbdr_read: got %h lat %0d want 0041 lat 1", rd, lat); end
        do_access(1'b0, 16'hFE00, 16'h0000, rd, lat);
        n_checks++; if (rd !== 16'h0000) begin n_fail++; $display("FAIL kbsr_cleared: got %h want 0000", rd); end
        // New keystroke on the same edge as a KBDR read.
        KB_Data = 8'h41; KB_Valid = 1'b1; tick(); KB_Valid = 1'b0;
        MIO_EN = 1'b1; R_W = 1'b0; Address = 16'hFE02;
        KB_Data = 8'h42; KB_Valid = 1'b1;
        tick();
        KB_Valid = 1'b0;
        n_checks++; if (R !== 1'b1 || Data_Out !== 16'h0041) begin
            n_fail++; $display("FAIL kb_collision_read: got R=%b %h want 1 0041", R, Data_Out); end
        MIO_EN = 1'b0;
        tick();
        do_access(1'b0, 16'hFE00, 16'h0000, rd, lat);
        n_checks++; if (rd !== 16'h8000) begin n_fail++; $display("FAIL kb_collision_ready: got %h want 8000", rd); end
        do_access(1'b0, 16'hFE02, 16'h0000, rd, lat);
        n_checks++; if (rd !== 16'h0042) begin n_fail++; $display("FAIL kb_collision_data: got %h want 0042", rd); end
    endtask

    task automatic test_display();
        logic [15:0] rd;
        int lat;
        DSP_Ready = 1'b1;
        do_access(1'b0, 16'hFE04, 16'h0000, rd, lat);
        n_checks++; if (rd !== 16'h8000) begin n_fail++; $display("FAIL dsr_ready: got %h want 8000", rd); end
        DSP_Ready = 1'b0;
        do_access(1'b0, 16'hFE04, 16'h0000, rd, lat);
        n_checks++; if (rd !== 16'h0000) begin n_fail++; $display("FAIL dsr_busy: got %h want 0000", rd); end
        MIO_EN = 1'b1; R_W = 1'b1; Address = 16'hFE06; Data_In = 16'h0158;
        n_checks++; if (DSP_Valid !== 1'b0) begin n_fail++; $display("FAIL ddr_c0_valid: got %b want 0", DSP_Valid); end
        tick();
        n_checks++; if (R !== 1'b1 || DSP_Valid !== 1'b1 || DSP_Data !== 8'h58) begin
            n_fail++; $display("FAIL ddr_write: got R=%b V=%b D=%h want 1/1/58", R, DSP_Valid, DSP_Data); end
        n_checks++; if (SRAM_CE_N !== 1'b1 || Data_Out !== 16'h0000) begin
            n_fail++; $display("FAIL ddr_side: got CE_N=%b Data_Out=%h want 1/0000", SRAM_CE_N, Data_Out); end
        MIO_EN = 1'b0;
        tick();
        n_checks++; if (DSP_Valid !== 1'b0 || R !== 1'b0) begin
            n_fail++; $display("FAIL ddr_pulse_end: got V=%b R=%b want 0/0", DSP_Valid, R); end
        do_access(1'b1, 16'hFE00, 16'hFFFF, rd, lat);
        do_access(1'b0, 16'hFE08, 16'h0000, rd, lat);
        n_checks++; if (rd !== 16'h0000 || lat !== 1) begin
            n_fail++; $display("FAIL unmapped_dev: got %h lat %0d want 0000 lat 1", rd, lat); end
        n_checks++; if (DSP_Data !== 8'h58) begin n_fail++; $display("FAIL ddr_hold: got %h want 58", DSP_Data); end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        MIO_EN = 1'b1; R_W = 1'b0; Address = 16'h3000;
        for (int c = 1; c <= 11; c++) begin
            tick();
            if (R === 1'b1) pulses++;
            n_checks++; if (R !== (c == 4 || c == 9)) begin
                n_fail++; $display("FAIL b2b_R c%0d: got %b want %b", c, R, (c == 4 || c == 9)); end
            if (c == 9) MIO_EN = 1'b0;
        end
        n_checks++; if (pulses !== 2) begin n_fail++; $display("FAIL b2b_pulses: got %0d want 2", pulses); end
    endtask

    task automatic test_mio_drop();
        logic [15:0] rd;
        int lat;
        do_access(1'b0, 16'h4000, 16'h0000, rd, lat);
        MIO_EN = 1'b1; R_W = 1'b0; Address = 16'h3000;
        tick();
        MIO_EN = 1'b0;
        for (int c = 2; c <= 5; c++) begin
            tick();
            n_checks++; if (R !== (c == 4)) begin
                n_fail++; $display("FAIL drop_R c%0d: got %b want %b", c, R, (c == 4)); end
        end
        n_checks++; if (Data_Out !== 16'hBEEF) begin n_fail++; $display("FAIL drop_data: got %h want beef", Data_Out); end
    endtask

    task automatic test_reset_mid_write();
        logic [15:0] rd;
        int lat;
        KB_Data = 8'h55; KB_Valid = 1'b1; tick(); KB_Valid = 1'b0;
        MIO_EN = 1'b1; R_W = 1'b1; Address = 16'h5000; Data_In = 16'hAAAA;
        tick(); tick();
        n_checks++; if (SRAM_WE_N !== 1'b0) begin n_fail++; $display("FAIL rst_pre_we: got %b want 0", SRAM_WE_N); end
        #1 Reset = 1'b1;
        #1;
        n_checks++; if ({SRAM_WE_N, SRAM_CE_N, SRAM_DQ_OE, R} !== 4'b1100) begin
            n_fail++; $display("FAIL rst_async_strobes: got %b want 1100", {SRAM_WE_N, SRAM_CE_N, SRAM_DQ_OE, R}); end
        MIO_EN = 1'b0;
        tick(); tick();
        Reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            n_checks++; if (R !== 1'b0 || SRAM_CE_N !== 1'b1) begin
                n_fail++; $display("FAIL rst_idle c%0d: got R=%b CE_N=%b want 0/1", c, R, SRAM_CE_N); end
        end
        n_checks++; if (Data_Out !== 16'h0000) begin n_fail++; $display("FAIL rst_dataout: got %h want 0000", Data_Out); end
        do_access(1'b0, 16'hFE00, 16'h0000, rd, lat);
        n_checks++; if (rd !== 16'h0000 || lat !== 1) begin
            n_fail++; $display("FAIL rst_kb_cleared: got %h lat %0d want 0000 lat 1", rd, lat); end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        mem[16'h3000] = 16'hBEEF;
        test_reset();
        test_sram_read();
        tick();
        test_sram_write();
        test_keyboard();
        test_display();
        test_back_to_back();
        tick();
        test_mio_drop();
        tick();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
